// File: rtl/sensor_pkg.sv
// Shared types and the sensor error equation for the sensor fault monitor.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MONITOR    = 3'd1,
    DEBOUNCE   = 3'd2,
    FAULT      = 3'd3,
    WAIT_CLEAR = 3'd4
  } mon_state_t;

  localparam int SENSOR_W = 4;

  function automatic logic sensor_err(input logic [SENSOR_W-1:0] s);
    return s[0] | (s[1] & (s[3] | s[2]));
  endfunction

endpackage

// File: rtl/sensor_fault_monitor_debounce_cnt.sv
// Debounce run-length counter; terminal flags the last cycle before a fault is declared.
module debounce_cnt #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt_r;

  // Clear takes priority but still admits a count in the same cycle (restart at one).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= CW'(0);
    end else if (clear) begin
      cnt_r <= count_en ? CW'(1) : CW'(0);
    end else if (count_en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign terminal = (cnt_r == CW'(DEBOUNCE - 1));

endmodule

// File: rtl/sensor_fault_monitor.sv
// Sensor fault sequencer: synchronises sensors, debounces the error, latches a fault
// interrupt with snapshot and saturating count, and waits for ack plus a clear condition.
module sensor_fault_monitor #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       sensors,
  input  logic             enable,
  input  logic             ack,
  input  logic             clear_count,
  output logic             fault_irq,
  output logic [3:0]       fault_snap,
  output logic [CNT_W-1:0] fault_count,
  output logic             busy
);

  import sensor_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0] sync1_r, sync2_r;
  mon_state_t state_r;
  logic raw_err_s, terminal_s, cnt_clear_s, cnt_en_s, enter_fault_s;

  assign raw_err_s = sensor_err(sync2_r);

  // Decide whether this edge declares a fault (DEBOUNCE==1 skips the DEBOUNCE state).
  always_comb begin
    enter_fault_s = 1'b0;
    if (enable && raw_err_s) begin
      if (state_r == MONITOR) begin
        enter_fault_s = (DEBOUNCE == 1);
      end else if (state_r == sensor_pkg::DEBOUNCE) begin
        enter_fault_s = terminal_s;
      end else begin
        enter_fault_s = 1'b0;
      end
    end else begin
      enter_fault_s = 1'b0;
    end
  end

  assign cnt_en_s    = enable && raw_err_s &&
                       (state_r == MONITOR || state_r == sensor_pkg::DEBOUNCE);
  assign cnt_clear_s = !(enable && raw_err_s && state_r == sensor_pkg::DEBOUNCE);

  debounce_cnt #(.DEBOUNCE(DEBOUNCE)) u_debounce_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear_s),
    .count_en (cnt_en_s),
    .terminal (terminal_s)
  );

  // Two-flop synchroniser per sensor bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= sensors;
      sync2_r <= sync1_r;
    end
  end

  // Monitor state machine; enable is deliberately ignored while a fault is pending.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:       state_r <= enable ? MONITOR : IDLE;
        MONITOR: begin
          if (!enable)            state_r <= IDLE;
          else if (enter_fault_s) state_r <= FAULT;
          else if (raw_err_s)     state_r <= sensor_pkg::DEBOUNCE;
          else                    state_r <= MONITOR;
        end
        sensor_pkg::DEBOUNCE: begin
          if (!enable)            state_r <= IDLE;
          else if (!raw_err_s)    state_r <= MONITOR;
          else if (enter_fault_s) state_r <= FAULT;
          else                    state_r <= sensor_pkg::DEBOUNCE;
        end
        FAULT:      state_r <= ack ? WAIT_CLEAR : FAULT;
        WAIT_CLEAR: begin
          if (!raw_err_s) state_r <= enable ? MONITOR : IDLE;
          else            state_r <= WAIT_CLEAR;
        end
        default:    state_r <= IDLE;
      endcase
    end
  end

  // Snapshot and saturating fault counter; a coincident clear restarts the count at one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fault_snap  <= 4'b0000;
      fault_count <= CNT_W'(0);
    end else if (enter_fault_s) begin
      fault_snap <= sync2_r;
      if (clear_count)                fault_count <= CNT_W'(1);
      else if (fault_count != CNT_MAX) fault_count <= fault_count + CNT_W'(1);
      else                            fault_count <= fault_count;
    end else if (clear_count) begin
      fault_snap  <= fault_snap;
      fault_count <= CNT_W'(0);
    end else begin
      fault_snap  <= fault_snap;
      fault_count <= fault_count;
    end
  end

  assign fault_irq = (state_r == FAULT);
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Bench for sensor_fault_monitor: two configurations driven in lockstep and checked
// against a run-length reference model, with directed scenarios followed by random traffic.
module tb_sensor_fault_monitor;
  import sensor_pkg::*;

  localparam int P_IDLE = 0, P_WATCH = 1, P_FAULT = 2, P_HOLD = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] sensors = 4'b0000;
  logic enable = 1'b0, ack = 1'b0, clear_count = 1'b0;

  logic       irq0, busy0, irq1, busy1;
  logic [3:0] snap0, snap1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int checks = 0;
  int failures = 0;

  int D[2]    = '{4, 1};
  int MAXC[2] = '{255, 3};
  int ph[2], run[2], mcnt[2];
  logic [3:0] msnap[2], ms1[2], ms2[2];

  always #5 clk = ~clk;

  sensor_fault_monitor #(.DEBOUNCE(4), .CNT_W(8)) dut0 (
    .clk(clk), .n_rst(n_rst), .sensors(sensors), .enable(enable), .ack(ack),
    .clear_count(clear_count), .fault_irq(irq0), .fault_snap(snap0),
    .fault_count(cnt0), .busy(busy0));

  sensor_fault_monitor #(.DEBOUNCE(1), .CNT_W(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .sensors(sensors), .enable(enable), .ack(ack),
    .clear_count(clear_count), .fault_irq(irq1), .fault_snap(snap1),
    .fault_count(cnt1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; run[k] = 0; mcnt[k] = 0;
      msnap[k] = 4'b0000; ms1[k] = 4'b0000; ms2[k] = 4'b0000;
    end
  endtask

  // One clock edge of the reference model: error run length against the debounce depth.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit err, entered;
      err = sensor_err(ms2[k]);
      entered = 1'b0;
      case (ph[k])
        P_IDLE:  if (enable) ph[k] = P_WATCH;
        P_WATCH: begin
          if (!enable) begin
            ph[k] = P_IDLE; run[k] = 0;
          end else if (err) begin
            run[k]++;
            if (run[k] >= D[k]) begin
              ph[k] = P_FAULT; run[k] = 0; entered = 1'b1;
              msnap[k] = ms2[k];
              mcnt[k] = clear_count ? 1 : ((mcnt[k] + 1 > MAXC[k]) ? MAXC[k] : mcnt[k] + 1);
            end
          end else begin
            run[k] = 0;
          end
        end
        P_FAULT: if (ack) ph[k] = P_HOLD;
        P_HOLD:  if (!err) ph[k] = enable ? P_WATCH : P_IDLE;
        default: ph[k] = P_IDLE;
      endcase
      if (!entered && clear_count) mcnt[k] = 0;
      ms2[k] = ms1[k];
      ms1[k] = sensors;
    end
  endtask

  function automatic bit will_enter(input int k);
    return ph[k] == P_WATCH && enable && sensor_err(ms2[k]) && (run[k] + 1 >= D[k]);
  endfunction

  task automatic check_all();
    chk("irq0",  irq0,  32'(ph[0] == P_FAULT));
    chk("busy0", busy0, 32'(ph[0] != P_IDLE));
    chk("snap0", snap0, 32'(msnap[0]));
    chk("cnt0",  cnt0,  32'(mcnt[0]));
    chk("irq1",  irq1,  32'(ph[1] == P_FAULT));
    chk("busy1", busy1, 32'(ph[1] != P_IDLE));
    chk("snap1", snap1, 32'(msnap[1]));
    chk("cnt1",  cnt1,  32'(mcnt[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    #1;
    model_reset();
    chk({tag, "_irq0"}, irq0, 32'd0);
    chk({tag, "_busy0"}, busy0, 32'd0);
    chk({tag, "_cnt0"}, cnt0, 32'd0);
    chk({tag, "_snap0"}, snap0, 32'd0);
    check_all();
    n_rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("por");
    steps(2);

    // Nominal fault with latency measured from the edge that samples the pattern.
    enable = 1'b1;
    steps(3);
    sensors = 4'b0001;
    for (int i = 0; i <= 5; i++) begin
      step();
      chk("latency_irq0", irq0, 32'(i == 5));
    end
    chk("nominal_snap", snap0, 32'd1);
    chk("nominal_cnt", cnt0, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_irq0", irq0, 32'd0);
    sensors = 4'b0000;
    steps(4);
    chk("back_monitor", busy0, 32'd1);

    // Short glitch and a non-error pattern.
    sensors = 4'b0110; steps(3);
    sensors = 4'b0000; steps(6);
    chk("glitch_cnt0", cnt0, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    sensors = 4'b1100; steps(20);
    chk("noerr_irq0", irq0, 32'd0);
    sensors = 4'b0000; steps(3);

    // Persistent fault: after ack no re-trigger until the condition clears.
    sensors = 4'b1010; steps(7);
    ack = 1'b1; step(); ack = 1'b0;
    steps(10);
    chk("persist_irq0", irq0, 32'd0);
    chk("persist_busy0", busy0, 32'd1);
    sensors = 4'b0000; steps(4);

    // Repeated faults saturate the narrow counter; clear coincident with an entry gives one.
    for (int f = 1; f <= 6; f++) begin
      sensors = 4'b0001;
      for (int t = 0; t < 20 && ph[1] != P_FAULT; t++) begin
        if (f == 6 && will_enter(1)) clear_count = 1'b1;
        step();
        clear_count = 1'b0;
      end
      chk("fault_wait1", irq1, 32'd1);
      if (f == 5) chk("sat_cnt1", cnt1, 32'd3);
      if (f == 6) chk("clear_entry_cnt1", cnt1, 32'd1);
      sensors = 4'b0000;
      ack = 1'b1; step(); ack = 1'b0;
      steps(8);
    end

    // Enable drop in DEBOUNCE returns to IDLE; in FAULT the interrupt is held.
    sensors = 4'b0001; steps(3);
    enable = 1'b0; step();
    chk("en_drop_busy0", busy0, 32'd0);
    steps(4);
    chk("en_drop_irq1", irq1, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    sensors = 4'b0000; steps(3);
    enable = 1'b1; steps(2);

    // Reset mid-DEBOUNCE and mid-FAULT.
    sensors = 4'b0001; steps(3);
    do_reset("rst_deb");
    steps(6);
    do_reset("rst_fault");
    sensors = 4'b0000; steps(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) sensors = 4'($urandom);
      enable      = ($urandom_range(15) != 0);
      ack         = ($urandom_range(7) == 0);
      clear_count = ($urandom_range(63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
